// File: rtl/mxu_core.sv
// DIM x DIM unsigned matrix-multiply engine: Y = A*B, one inner-product index per cycle.
// Results wrap modulo 2^WIDTH; a one-cycle finished pulse marks each new out value.
module mxu_core #(
    parameter int DIM   = 4,
    parameter int WIDTH = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    input  logic [DIM-1:0][DIM-1:0][WIDTH-1:0]   in0,
    input  logic [DIM-1:0][DIM-1:0][WIDTH-1:0]   in1,
    output logic [DIM-1:0][DIM-1:0][WIDTH-1:0]   out,
    output logic                                 finished,
    output logic                                 busy
);

    localparam int            KW     = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(DIM - 1);

    typedef enum logic {IDLE, COMPUTE} state_t;

    state_t                               state, state_nxt;
    logic                                 load, step, done;
    logic [KW-1:0]                        k;
    logic [DIM-1:0][DIM-1:0][WIDTH-1:0]   a_q, b_q;
    logic [DIM-1:0][DIM-1:0][WIDTH-1:0]   acc, acc_nxt;

    // Only the low WIDTH bits of the 2*WIDTH product survive, so the
    // multiply is evaluated directly at WIDTH bits.
    function automatic logic [WIDTH-1:0] mul_trunc(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        return a * b;
    endfunction

    function automatic logic [WIDTH-1:0] mac_wrap(input logic [WIDTH-1:0] sum,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        return sum + mul_trunc(a, b);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = COMPUTE;
                end
            end
            COMPUTE: begin
                step = 1'b1;
                if (k == K_LAST) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == COMPUTE);

    // One rank-1 update per cycle: column k of A times row k of B.
    always_comb begin
        acc_nxt = acc;
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                acc_nxt[i][j] = mac_wrap(acc[i][j], a_q[i][k], b_q[k][j]);
            end
        end
    end

    // Operand copies are only read while COMPUTE, after a load has filled them.
    always_ff @(posedge clk) begin
        if (load) begin
            a_q <= in0;
            b_q <= in1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k        <= '0;
            acc      <= '0;
            out      <= '0;
            finished <= 1'b0;
        end else begin
            finished <= done;
            if (load) begin
                acc <= '0;
                k   <= '0;
            end else if (step) begin
                acc <= acc_nxt;
                k   <= done ? '0 : k + 1'b1;
            end
            if (done) begin
                out <= acc_nxt;
            end
        end
    end

endmodule
